// File: rtl/mic_level_meter_pkg.sv
// rtl/mic_level_meter_pkg.sv - shared widths, FSM encoding and magnitude helper for the mic level meter
package mic_level_meter_pkg;

    localparam int MIC_W        = 12;
    localparam int MAG_W        = 11;
    localparam int LVL_W        = 4;
    localparam int MIC_MIDPOINT = 2048;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Distance of a raw sample from the DC midpoint, saturated to the MAG_W range.
    function automatic logic [MAG_W-1:0] sample_mag(input logic [MIC_W-1:0] s,
                                                    input logic [MIC_W:0]   mid);
        logic [MIC_W:0] ext;
        logic [MIC_W:0] diff;
        ext  = {1'b0, s};
        diff = (ext >= mid) ? (ext - mid) : (mid - ext);
        if (diff > {{(MIC_W+1-MAG_W){1'b0}}, {MAG_W{1'b1}}}) begin
            return {MAG_W{1'b1}};
        end
        return diff[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/mic_level_meter_edge_strobe.sv
// rtl/mic_level_meter_edge_strobe.sv - 2-FF synchronizer plus rising-edge detector for slow clock domains
module edge_strobe (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic stb_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            prev_q <= sync_q[1];
        end
    end

    assign stb_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/mic_level_meter.sv
// rtl/mic_level_meter.sv - windowed peak magnitude to 4-bit volume level with hold and one-step decay
module mic_level_meter
    import mic_level_meter_pkg::*;
#(
    parameter int WINDOW   = 4000,
    parameter int MIDPOINT = MIC_MIDPOINT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cs,
    input  logic [MIC_W-1:0] mic_in,
    output logic [LVL_W-1:0] level,
    output logic [MAG_W-1:0] peak,
    output logic             level_valid,
    output logic             clip
);

    localparam int                CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(WINDOW - 1);
    localparam logic [MIC_W:0]    MID_EX = (MIC_W+1)'(MIDPOINT);

    logic stb;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [MAG_W-1:0] run_max_q,  run_max_d;
    logic             clip_acc_q, clip_acc_d;
    logic [LVL_W-1:0] level_q,    level_d;
    logic [MAG_W-1:0] peak_q,     peak_d;
    logic             clip_q,     clip_d;
    logic             valid_q,    valid_d;

    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] new_max;
    logic             clip_new;
    logic [LVL_W-1:0] new_lvl;

    edge_strobe u_cs_strobe (
        .clk     (clk),
        .rst_n   (rst),
        .async_i (cs),
        .stb_o   (stb)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_max_d  = run_max_q;
        clip_acc_d = clip_acc_q;
        level_d    = level_q;
        peak_d     = peak_q;
        clip_d     = clip_q;
        valid_d    = 1'b0;

        mag      = sample_mag(mic_in, MID_EX);
        new_max  = (mag > run_max_q) ? mag : run_max_q;
        clip_new = clip_acc_q | (mic_in == '0) | (mic_in == '1);
        new_lvl  = new_max[MAG_W-1 -: LVL_W];

        unique case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                run_max_d  = '0;
                clip_acc_d = 1'b0;
                if (en) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // Enable loss wins over a coincident last strobe: partial window is dropped.
                if (!en) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    run_max_d  = '0;
                    clip_acc_d = 1'b0;
                end else if (stb) begin
                    if (cnt_q == LAST) begin
                        state_d    = ST_COMMIT;
                        peak_d     = new_max;
                        clip_d     = clip_new;
                        level_d    = (new_lvl >= level_q) ? new_lvl : (level_q - 1'b1);
                        valid_d    = 1'b1;
                        cnt_d      = '0;
                        run_max_d  = '0;
                        clip_acc_d = 1'b0;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        run_max_d  = new_max;
                        clip_acc_d = clip_new;
                    end
                end
            end
            ST_COMMIT: begin
                // A strobe landing here is intentionally dropped.
                state_d = en ? ST_ACCUM : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            run_max_q  <= '0;
            clip_acc_q <= 1'b0;
            level_q    <= '0;
            peak_q     <= '0;
            clip_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_max_q  <= run_max_d;
            clip_acc_q <= clip_acc_d;
            level_q    <= level_d;
            peak_q     <= peak_d;
            clip_q     <= clip_d;
            valid_q    <= valid_d;
        end
    end

    assign level       = level_q;
    assign peak        = peak_q;
    assign level_valid = valid_q;
    assign clip        = clip_q;

endmodule

// File: tb/tb_mic_level_meter.sv
// tb/tb_mic_level_meter.sv - directed self-checking bench for mic_level_meter with an 8-sample window
module tb_mic_level_meter;

    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        cs  = 1'b0;
    logic [11:0] mic_in = 12'd2048;
    logic [3:0]  level;
    logic [10:0] peak;
    logic        level_valid;
    logic        clip;

    int total = 0;
    int bad   = 0;
    int np;
    int fa;

    mic_level_meter #(.WINDOW(8), .MIDPOINT(2048)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cs          (cs),
        .mic_in      (mic_in),
        .level       (level),
        .peak        (peak),
        .level_valid (level_valid),
        .clip        (clip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int e_lvl, input int e_peak, input int e_clip);
        chk({tag, ".level"}, int'(level), e_lvl);
        chk({tag, ".peak"},  int'(peak),  e_peak);
        chk({tag, ".clip"},  int'(clip),  e_clip);
    endtask

    // One cs period; counts level_valid pulses and the first negedge index they appear at.
    task automatic send(input logic [11:0] v, output int npulse, output int first_at);
        mic_in = v;
        @(negedge clk);
        cs       = 1'b1;
        npulse   = 0;
        first_at = -1;
        for (int i = 1; i <= 2 * HALF; i++) begin
            if (i == HALF + 1) cs = 1'b0;
            @(negedge clk);
            if (level_valid) begin
                npulse++;
                if (first_at < 0) first_at = i;
            end
        end
    endtask

    task automatic send_n(input logic [11:0] v, input int n, output int npulse, output int last_first);
        int p;
        int f;
        npulse     = 0;
        last_first = -1;
        for (int k = 0; k < n; k++) begin
            send(v, p, f);
            npulse    += p;
            last_first = f;
        end
    endtask

    // Seven quiet samples after a leading sample; returns pulses over the window.
    task automatic window_one(input logic [11:0] first, output int npulse, output int last_first);
        int p0;
        int f0;
        send(first, p0, f0);
        send_n(12'd2048, 7, npulse, last_first);
        npulse += p0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.level", int'(level), 0);
        chk("rst.peak",  int'(peak), 0);
        chk("rst.valid", int'(level_valid), 0);
        chk("rst.clip",  int'(clip), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_outs("por", 0, 0, 0);
        chk("por.valid", int'(level_valid), 0);
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);

        // Reset mid-window, then seven samples must not complete a window.
        send_n(12'd4095, 4, np, fa);
        chk("pre_rst.pulses", np, 0);
        do_reset();
        send_n(12'd4095, 7, np, fa);
        chk("post_rst.pulses", np, 0);
        chk_outs("post_rst", 0, 0, 0);
        en = 1'b0;
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);

        // Silence.
        send_n(12'd2048, 8, np, fa);
        chk("quiet.pulses", np, 1);
        chk("quiet.latency_ok", int'(fa >= 3 && fa <= 4), 1);
        chk_outs("quiet", 0, 0, 0);

        // One loud sample above midpoint, then four quiet windows of decay.
        window_one(12'd3072, np, fa);
        chk("hi.pulses", np, 1);
        chk_outs("hi", 8, 1024, 0);
        for (int w = 0; w < 4; w++) begin
            send_n(12'd2048, 8, np, fa);
            chk("decay.pulses", np, 1);
            chk_outs("decay", 7 - w, 0, 0);
        end

        // Rail sample: saturated magnitude and clip, cleared by the next clean window.
        window_one(12'd0, np, fa);
        chk_outs("rail", 15, 2047, 1);
        send_n(12'd2048, 8, np, fa);
        chk_outs("after_rail", 14, 0, 0);

        // Enable drop discards a partial window.
        do_reset();
        send_n(12'd4000, 5, np, fa);
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("en_drop.pulses", np, 0);
        chk_outs("en_drop", 0, 0, 0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        send_n(12'd2176, 8, np, fa);
        chk("reen.pulses", np, 1);
        chk_outs("reen", 1, 128, 0);

        // Below midpoint mirrors the 3072 case.
        do_reset();
        window_one(12'd1024, np, fa);
        chk("lo.pulses", np, 1);
        chk_outs("lo", 8, 1024, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
